resp_sig_compactor: RTL
=======================

// Module: resp_sig_compactor
// PURPOSE
//   Response-side end of the pattern interface: accepts one DUT output response per
//   applied pattern and compacts the stream into a MISR signature.
//   Counts the accepted patterns and compares the final signature against a golden
//   value, giving a single pass/fail per pattern set.
//   Sits between the DUT outputs and the fault-sim bench, in place of per-pattern
//   output logging.
// PARAMETERS
//   WIDTH  1         response bits per pattern (pattout width); WIDTH <= SIG_W
//   SIG_W  16        signature register width
//   POLY   16'h1021  MISR feedback polynomial (x^SIG_W term implicit)
//   SEED   0         signature value loaded on start
//   CNT_W  16        width of pattern counter and num_pats
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      begin a compaction run (sampled only in IDLE/DONE)
//   abort      in   1      abandon current run, return to IDLE
//   num_pats   in   CNT_W  responses expected this run; sampled on start
//   golden     in   SIG_W  expected final signature; sampled on start
//   resp_valid in   1      resp_data holds a response
//   resp_ready out  1      block accepts a response this cycle
//   resp_data  in   WIDTH  DUT response
//   busy       out  1      run in progress (RUN state)
//   done       out  1      run complete; signature/pass valid
//   pass       out  1      signature == golden (valid while done)
//   signature  out  SIG_W  current MISR contents
//   pat_count  out  CNT_W  responses accepted this run
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE; resp_ready=0, busy=0, done=0, pass=0;
//     signature=SEED; pat_count=0. All outputs are registered.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE, start=1: load signature=SEED, pat_count=0, latch num_pats and golden.
//     Next state is RUN; if num_pats==0, next state is DONE, and pass=(SEED==golden).
//   - RUN: resp_ready=1 and busy=1. A transfer happens when resp_valid & resp_ready.
//     On each transfer:
//       sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zext(resp_data)
//       pat_count increments by 1.
//     If resp_valid=0, nothing changes.
//   - RUN -> DONE: in the same cycle that the transfer makes pat_count == latched
//     num_pats. From the next cycle: resp_ready=0, busy=0, done=1,
//     pass=(sig_next==golden_latched). No response is accepted after the last one.
//   - DONE: outputs hold. start=1 behaves exactly as start in IDLE, so back-to-back
//     runs need no IDLE visit. done and pass clear on that same edge.
//   - start while in RUN is ignored.
//   - abort=1 (any state, synchronous): next state IDLE; busy, done, pass and
//     resp_ready clear; signature and pat_count hold for debug.
//     abort has priority over start and over a simultaneous transfer; that
//     transfer is dropped and not counted.
//   - pat_count never wraps: RUN exits when it reaches num_pats (num_pats <= 2^CNT_W-1).
//   - Latency: a response accepted at edge N is reflected in signature after edge N.
//     done rises one cycle after the last response is accepted.
//   - Asserting rst mid-run returns to reset values immediately; no partial result
//     is kept.
// TESTING (SIG_W=8, POLY=8'h1D, WIDTH=1 unless noted)
//   1. SEED=0, num_pats=4, golden=8'h0D, responses 1,1,0,1, valid every cycle
//      -> signature steps 01,03,06,0D; done=1, pass=1, pat_count=4.
//   2. Same run with golden=8'h0C -> done=1, pass=0, signature=8'h0D.
//   3. SEED=8'h80, num_pats=1, response 0 -> signature=8'h1D (feedback from MSB).
//   4. num_pats=4, resp_valid low on alternating cycles -> only the valid cycles
//      are counted; done after the 4th accept; resp_ready=0 in DONE.
//   5. num_pats=0, start -> DONE next cycle, pass=(SEED==golden), no transfers.
//   6. abort together with the 2nd valid response -> IDLE, pat_count=1.
//      Then assert rst mid-run -> all outputs at reset values that cycle.

Source files
------------

// File: rtl/resp_sig_compactor_if.sv
// Response handshake between the DUT-output side (master) and the compactor (slave).
interface resp_sig_compactor_if #(
  parameter int WIDTH = 1
);
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;

  // Producer presents responses and observes back-pressure.
  modport master (output resp_valid, output resp_data, input resp_ready);
  // Compactor consumes responses and drives back-pressure.
  modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/resp_sig_compactor.sv
// MISR response compactor: accepts one response per pattern, folds it into a
// signature, counts patterns and flags pass/fail against a golden signature.
module resp_sig_compactor #(
  parameter int               WIDTH = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_pats,
  input  logic [SIG_W-1:0]     golden,
  resp_sig_compactor_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [CNT_W-1:0]     pat_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] golden_q, golden_d;

  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             xfer;

  // Zero-extend the response and compute the MISR step for the current signature.
  always_comb begin
    resp_ext              = '0;
    resp_ext[WIDTH-1:0]   = bus.resp_data;
    sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
    cnt_inc  = cnt_q + CNT_W'(1);
    xfer     = bus.resp_valid & ready_q;
  end

  // Next-state and next-output logic of the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: every _d defaults to its _q so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    golden_d = golden_q;

    if (abort) begin
      // Signature and count are left intact for debug; a simultaneous transfer is dropped.
      state_d = ST_IDLE;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sig_d    = SEED;
            cnt_d    = '0;
            num_d    = num_pats;
            golden_d = golden;
            if (num_pats == '0) begin
              state_d = ST_DONE;
              ready_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (SEED == golden);
            end else begin
              state_d = ST_RUN;
              ready_d = 1'b1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              pass_d  = 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            sig_d = sig_next;
            cnt_d = cnt_inc;
            // Ready drops on the same edge as the last accept, so nothing extra slips in.
            if (cnt_inc == num_q) begin
              state_d = ST_DONE;
              ready_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (sig_next == golden_q);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // Controller state and registered outputs; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= SEED;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      golden_q <= golden_d;
    end
  end

  assign bus.resp_ready = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign signature      = sig_q;
  assign pat_count      = cnt_q;

endmodule
